// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes and the write-FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts (single-byte beats).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] mask_s;

  // For a legal WRAP length, (beats - 1) equals len, so len is the wrap mask.
  always_comb begin
    incr_s = addr_i + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    mask_s = {{(ADDR_WIDTH-8){1'b0}}, len_i};
    case (burst_e'(burst_i))
      BURST_INCR: next_addr_o = incr_s;
      BURST_WRAP: next_addr_o = (addr_i & ~mask_s) | (incr_s & mask_s);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_slave_wr_ctrl.sv
// AXI write-channel slave: accepts AW/W, walks burst addresses into a byte memory
// write port and returns one B response per burst. All outputs are registered.
module axi_slave_wr_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            next_addr_wr
);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  burst_err_q, burst_err_d;
  logic                  err_q, err_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            nxt_q, nxt_d;

  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic                  last_beat_s;
  logic                  beat_err_s;
  logic                  aw_err_s;
  logic                  wstrb_unused;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr_s)
  );

  assign wstrb_unused = ^wstrb[3:1];
  assign last_beat_s  = (cnt_q == len_q);
  assign beat_err_s   = (addr_q >= ADDR_WIDTH'(MEM_DEPTH)) || (wlast != last_beat_s);
  assign aw_err_s     = (awsize != 3'd0) || (awburst == 2'b11) ||
                        ((awburst == 2'b10) && !wrap_len_ok(awlen));

  // Next-state and registered-output logic for the IDLE/DATA/RESP walk.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    burst_err_d = burst_err_q;
    err_d       = err_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    nxt_d       = nxt_q;
    case (state_q)
      ST_IDLE: begin
        if (awvalid && awready_q) begin
          addr_d      = awaddr;
          len_d       = awlen;
          burst_d     = awburst;
          id_d        = awid;
          cnt_d       = 8'd0;
          burst_err_d = aw_err_s;
          err_d       = aw_err_s;
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          state_d     = ST_DATA;
        end else begin
          awready_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (wvalid && wready_q) begin
          // Burst-level errors still drain every beat but never write.
          mem_we_d    = wstrb[0] && !burst_err_q && !beat_err_s;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata;
          nxt_d       = next_addr_s[3:0];
          addr_d      = next_addr_s;
          cnt_d       = cnt_q + 8'd1;
          err_d       = err_q || beat_err_s;
          if (last_beat_s) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = id_q;
            bresp_d   = (err_q || beat_err_s) ? RESP_SLVERR : RESP_OKAY;
            state_d   = ST_RESP;
          end else begin
            wready_d  = 1'b1;
          end
        end else begin
          mem_we_d    = 1'b0;
        end
      end
      ST_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      len_q       <= 8'd0;
      burst_q     <= 2'b00;
      id_q        <= {ID_WIDTH{1'b0}};
      cnt_q       <= 8'd0;
      burst_err_q <= 1'b0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      bid_q       <= {ID_WIDTH{1'b0}};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      nxt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
      err_q       <= err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      nxt_q       <= nxt_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign bid          = bid_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign next_addr_wr = nxt_q;

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Self-checking bench for axi_slave_wr_ctrl: directed cases plus random bursts
// checked against a behavioural model of beat addresses, writes and responses.
module tb_axi_slave_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [3:0]  next_addr_wr;

  int check_cnt = 0;
  int err_cnt   = 0;
  int we_cnt    = 0;
  int exp_we    = 0;

  logic [7:0] bdata [256];
  logic       bstrb [256];
  logic       bflip [256];

  logic [31:0] m_addr;
  int          m_len;
  logic [1:0]  m_burst;
  logic [3:0]  m_id;
  logic        m_berr;
  logic        m_err;

  axi_slave_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .next_addr_wr(next_addr_wr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat-address rules expressed with modular arithmetic over the burst size.
  function automatic logic [31:0] model_next(input logic [31:0] a, input int len, input logic [1:0] b);
    logic [31:0] n;
    n = 32'(len + 1);
    if (b == 2'b01) return a + 32'd1;
    if (b == 2'b10) return (a - (a % n)) + ((a + 32'd1) % n);
    return a;
  endfunction

  task automatic clear_beats();
    for (int i = 0; i < 256; i++) begin
      bdata[i] = 8'($urandom_range(0, 255));
      bstrb[i] = 1'b1;
      bflip[i] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_awready"}, awready, 0);
    check_eq({tag, "_wready"}, wready, 0);
    check_eq({tag, "_bvalid"}, bvalid, 0);
    check_eq({tag, "_bresp"}, bresp, 0);
    check_eq({tag, "_bid"}, bid, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_next_addr"}, next_addr_wr, 0);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] b, input logic [3:0] id);
    int g;
    m_addr  = a;
    m_len   = int'(len);
    m_burst = b;
    m_id    = id;
    m_berr  = (sz != 3'd0) || (b == 2'b11) || ((b == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    m_err   = m_berr;
    awaddr = a; awlen = len; awsize = sz; awburst = b; awid = id; awvalid = 1'b1;
    g = 0;
    while (awready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("aw_timeout", (g < 50), 1);
    @(negedge clk);
    awvalid = 1'b0;
    check_eq("aw_awready_low", awready, 0);
    check_eq("aw_wready_high", wready, 1);
  endtask

  task automatic send_beat(input int i);
    logic        lastb, wl, perr, wr;
    logic [31:0] nx;
    int          g;
    lastb = (i == m_len);
    wl    = lastb ^ bflip[i];
    perr  = (m_addr >= 32'd256) || (wl != lastb);
    wr    = !m_berr && !perr && bstrb[i];
    nx    = model_next(m_addr, m_len, m_burst);
    if ($urandom_range(0, 3) == 0) begin
      wvalid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    wdata = bdata[i];
    wstrb = {3'($urandom_range(0, 7)), bstrb[i]};
    wlast = wl;
    wvalid = 1'b1;
    g = 0;
    while (wready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq("w_timeout", (g < 50), 1);
    @(negedge clk);
    check_eq("beat_mem_we", mem_we, wr);
    if (wr) begin
      check_eq("beat_mem_addr", mem_addr, m_addr);
      check_eq("beat_mem_wdata", mem_wdata, bdata[i]);
      exp_we++;
    end
    if (!m_berr) check_eq("beat_next_addr", next_addr_wr, nx[3:0]);
    if (lastb) begin
      wvalid = 1'b0;
      check_eq("last_wready_low", wready, 0);
      check_eq("last_bvalid_high", bvalid, 1);
    end else begin
      check_eq("mid_wready_high", wready, 1);
    end
    m_err  = m_err || perr;
    m_addr = nx;
  endtask

  task automatic finish_b(input int delay);
    logic [1:0] er;
    er = m_err ? 2'b10 : 2'b00;
    bready = 1'b0;
    for (int k = 0; k < delay; k++) begin
      check_eq("stall_bvalid", bvalid, 1);
      check_eq("stall_bid", bid, m_id);
      check_eq("stall_bresp", bresp, er);
      check_eq("stall_awready", awready, 0);
      @(negedge clk);
    end
    check_eq("b_bvalid", bvalid, 1);
    check_eq("b_bid", bid, m_id);
    check_eq("b_bresp", bresp, er);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("b_done_bvalid", bvalid, 0);
    check_eq("b_done_awready", awready, 1);
    check_eq("write_count", we_cnt, exp_we);
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] b, input logic [3:0] id, input int delay);
    send_aw(a, len, sz, b, id);
    for (int i = 0; i <= int'(len); i++) send_beat(i);
    finish_b(delay);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00; awid = 4'd0;
    awvalid = 1'b0; wdata = 8'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_awready_rise", awready, 1);

    wvalid = 1'b1;
    wdata  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_eq("early_w_wready", wready, 0);
      check_eq("early_w_mem_we", mem_we, 0);
    end
    wvalid = 1'b0;

    clear_beats();
    for (int i = 0; i < 4; i++) bdata[i] = 8'hA0 + 8'(i);
    run_burst(32'h10, 8'd3, 3'd0, 2'b01, 4'd5, 0);

    clear_beats();
    run_burst(32'h0E, 8'd3, 3'd0, 2'b10, 4'd2, 1);

    clear_beats();
    bdata[0] = 8'h11; bdata[1] = 8'h22; bdata[2] = 8'h33;
    run_burst(32'h20, 8'd2, 3'd0, 2'b00, 4'd7, 0);

    clear_beats();
    run_burst(32'h30, 8'd1, 3'd1, 2'b01, 4'd1, 0);

    clear_beats();
    run_burst(32'hFF, 8'd1, 3'd0, 2'b01, 4'd9, 0);

    clear_beats();
    run_burst(32'h40, 8'd0, 3'd0, 2'b01, 4'hA, 5);

    clear_beats();
    bflip[1] = 1'b1;
    run_burst(32'h50, 8'd2, 3'd0, 2'b01, 4'd3, 0);

    clear_beats();
    bstrb[0] = 1'b0;
    run_burst(32'h60, 8'd1, 3'd0, 2'b01, 4'd4, 0);

    clear_beats();
    run_burst(32'h64, 8'd2, 3'd0, 2'b10, 4'd6, 0);
    clear_beats();
    run_burst(32'h68, 8'd1, 3'd0, 2'b11, 4'd8, 0);

    clear_beats();
    send_aw(32'h70, 8'd7, 3'd0, 2'b01, 4'd3);
    send_beat(0);
    send_beat(1);
    rst_n  = 1'b0;
    wvalid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    check_eq("midrst_writes_kept", we_cnt, exp_we);
    clear_beats();
    run_burst(32'h80, 8'd3, 3'd0, 2'b01, 4'hC, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  b;
      logic [7:0]  len;
      logic [2:0]  sz;
      int          r;
      clear_beats();
      r = $urandom_range(0, 9);
      if (r == 9)     b = 2'b11;
      else if (r < 3) b = 2'b00;
      else if (r < 6) b = 2'b01;
      else            b = 2'b10;
      if (b == 2'b10 && $urandom_range(0, 9) != 0) begin
        r = $urandom_range(0, 3);
        len = 8'((2 << r) - 1);
      end else begin
        len = 8'($urandom_range(0, 12));
      end
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      for (int i = 0; i <= int'(len); i++) begin
        bstrb[i] = ($urandom_range(0, 6) != 0);
        bflip[i] = ($urandom_range(0, 19) == 0);
      end
      run_burst(32'($urandom_range(0, 32'h10F)), len, sz, b, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_ctrl.md
# axi_slave_wr_ctrl

AXI write-channel slave controller sitting directly downstream of `axi_interface`: consumes the AW, W and B channels, walks each burst's beat addresses, and drives a simple single-port byte memory write port. Supports FIXED, INCR and WRAP bursts of up to 256 beats. Returns one B response per burst, with the accepted `awid` echoed.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 8, data width (one byte per beat)
- `ID_WIDTH`, 4, transaction ID width
- `MEM_DEPTH`, 256, bytes of backing memory; addresses ≥ MEM_DEPTH are out of range
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `awaddr`  in  ADDR_WIDTH  burst start address
- `awlen`  in  8  beats minus one
- `awsize`  in  3  bytes per beat (log2)
- `awburst`  in  2  00 FIXED, 01 INCR, 10 WRAP
- `awid`  in  ID_WIDTH  transaction ID
- `awvalid`  in  1 / `awready`  out  1
- `wdata`  in  DATA_WIDTH / `wstrb`  in  4 (bit 0 only used) / `wlast`  in  1
- `wvalid`  in  1 / `wready`  out  1
- `bid`  out  ID_WIDTH / `bresp`  out  2 / `bvalid`  out  1 / `bready`  in  1
- `mem_we`  out  1  memory write strobe
- `mem_addr`  out  ADDR_WIDTH  memory byte address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `next_addr_wr`  out  4  low 4 bits of the address for the next beat

## Operation
- FSM states: IDLE, DATA, RESP.
- **IDLE**
  - `awready`=1.
  - On an AW handshake, latch addr/len/size/burst/id, clear the beat counter and error flag, then go to DATA.
- **DATA**
  - `wready`=1.
  - Each W handshake issues one write at the current beat address, then advances the address and the counter.
  - When the counter reaches `awlen`, the handshake ends the burst and the FSM goes to RESP.
- **RESP**
  - `bvalid`=1 with `bid`=latched id.
  - Return to IDLE on `bready`.
- **Next-address rules**
  - FIXED: address unchanged.
  - INCR: address+1, modulo 2^ADDR_WIDTH. 4 KB crossing is not checked.
  - WRAP: len=awlen+1, base=addr & ~(len-1), next = base | ((addr+1) & (len-1)).
- **SLVERR conditions** (`bresp`=2'b10; otherwise 2'b00)
  - Burst-level errors: `awsize`≠0, `awburst`=11, or WRAP with `awlen` ∉ {1,3,7,15}. These suppress all writes, but the burst's beats are still drained.
  - Per-beat errors: address ≥ MEM_DEPTH, or `wlast` mismatching the final-beat position. These suppress that beat's write only.
- A beat with `wstrb[0]`=0 is accepted without a write and is not an error.
- A burst always ends after exactly `awlen`+1 beats, regardless of `wlast`.

## Timing
- Reset values (whole cycle `rst_n`=0): state IDLE, `awready`=0, `wready`=0, `bvalid`=0, `bresp`=0, `bid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `next_addr_wr`=0.
- `awready` rises the first cycle after reset deasserts.
- AW handshake at cycle N → `wready`=1 from N+1. `awready`=0 from N+1 until the return to IDLE.
- W handshake at cycle M → `mem_we`/`mem_addr`/`mem_wdata` registered and valid at M+1, for one cycle.
- Last-beat handshake at M → `wready`=0 and `bvalid`=1 at M+1, coinciding with the last `mem_we`.
- `bvalid`, `bid` and `bresp` hold stable until `bready`. A B handshake at K → `awready`=1 at K+1.
- Minimum burst turnaround: AW (1) + beats + B (1) + 1 idle cycle.
- `wvalid` before the AW handshake is not accepted (`wready`=0).
- Reset mid-burst: next edge goes to IDLE with all outputs at reset values. The partial burst is abandoned, no B is issued, and beats already written remain in memory.

## Structure
- Shared package `axi_pkg`:
  - burst enum (FIXED/INCR/WRAP/RSVD)
  - response constants (OKAY=2'b00, SLVERR=2'b10)
  - FSM state enum
- Sub-module `axi_burst_addr_gen`: combinational next-address calculation from addr/len/burst. It is reused later by the read-channel controller.

## Test plan
- INCR, awaddr=0x10, awlen=3, awid=5, wdata A0..A3 → writes 0x10..0x13 = A0..A3; `bresp`=00, `bid`=5.
- WRAP, awaddr=0x0E, awlen=3 → write addresses 0x0E, 0x0F, 0x0C, 0x0D; `next_addr_wr` sequence F, C, D, E; `bresp`=00.
- FIXED, awaddr=0x20, awlen=2, data 11/22/33 → three writes to 0x20, final value 33; `bresp`=00.
- awsize=1, awlen=1 → two beats accepted, `mem_we` never asserts, `bresp`=10. Likewise, INCR at 0xFF with awlen=1 → 0xFF written, 0x100 suppressed, `bresp`=10.
- `bready` held low 5 cycles after `bvalid` → `bvalid`/`bid`/`bresp` stable and `awready`=0 throughout; `awready`=1 the cycle after `bready`.
- `rst_n` low after beat 2 of an awlen=7 INCR burst → next cycle all outputs at reset values, no `bvalid`; a new burst then completes normally.
